// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    function automatic int calcNdig(input int width, input int digit);
        return width / digit;
    endfunction

    // One spare bit so the counter never needs a zero-width vector when NDIG == 1.
    function automatic int calcCntW(input int ndig);
        return $clog2(ndig) + 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also reports the carry into its top bit
// so the caller can form the signed-overflow flag on the last digit.
module digit_adder
    import addsub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] carryChain;

    always_comb begin
        sum        = '0;
        carryChain = '0;
        carryChain[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]          = x[i] ^ y[i] ^ carryChain[i];
            carryChain[i+1] = (x[i] & y[i]) | (carryChain[i] & (x[i] ^ y[i]));
        end
    end

    assign cout     = carryChain[DIGIT];
    assign c_msb_in = carryChain[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// WIDTH-bit add/subtract processed DIGIT bits per cycle, LSB first, with registered
// result and NZCV flags that only change on the single-cycle DONE update.
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [1:0]       stateDbg
);

    localparam int NDIG  = calcNdig(WIDTH, DIGIT);
    localparam int CNT_W = calcCntW(NDIG);

    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : gBadParams
        $error("digit_serial_addsub: WIDTH must be a positive multiple of DIGIT");
    end

    state_t             state, stateNext;
    logic               accept;
    logic               lastDigit;
    logic [CNT_W-1:0]   digitCnt;
    logic [WIDTH-1:0]   aSh, bSh, acc, accNext, sumWide;
    logic               carry;
    logic [DIGIT-1:0]   digSum;
    logic               digCout, digCmsb;
    op_t                opSel;

    assign opSel     = op_t'(op);
    assign lastDigit = (digitCnt == CNT_W'(NDIG - 1));

    // Valid/ready: a request is taken when start=1 and the unit is not in RUN;
    // start during RUN is dropped, never queued.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (lastDigit) stateNext = DONE;
            end
            DONE: begin
                if (start) begin
                    stateNext = RUN;
                    accept    = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    digit_adder #(.DIGIT(DIGIT)) uDigitAdder (
        .x        (aSh[DIGIT-1:0]),
        .y        (bSh[DIGIT-1:0]),
        .cin      (carry),
        .sum      (digSum),
        .cout     (digCout),
        .c_msb_in (digCmsb)
    );

    // New digit enters from the MSB side; after NDIG shifts the word is aligned.
    assign sumWide = WIDTH'(digSum);
    assign accNext = (acc >> DIGIT) | (sumWide << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aSh      <= '0;
            bSh      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            digitCnt <= '0;
            result   <= '0;
            flag_n   <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
        end else if (accept) begin
            aSh      <= a;
            bSh      <= (opSel == OP_SUB) ? ~b : b;
            carry    <= (opSel == OP_SUB);
            acc      <= '0;
            digitCnt <= '0;
        end else if (state == RUN) begin
            aSh      <= aSh >> DIGIT;
            bSh      <= bSh >> DIGIT;
            acc      <= accNext;
            carry    <= digCout;
            digitCnt <= digitCnt + 1'b1;
            if (lastDigit) begin
                result <= accNext;
                flag_n <= accNext[WIDTH-1];
                flag_z <= (accNext == '0);
                flag_c <= digCout;
                flag_v <= digCmsb ^ digCout;
            end
        end
    end

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign stateDbg = state;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench for digit_serial_addsub: a 16/4 instance for most scenarios and
// a 16/16 instance for the single-cycle configuration.
module tb_digit_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        start, start2;
    logic        op;
    logic [15:0] a, b;
    logic        busy, done, flagN, flagZ, flagC, flagV;
    logic [15:0] result;
    logic [1:0]  stateDbg;
    logic        busy2, done2, flagN2, flagZ2, flagC2, flagV2;
    logic [15:0] result2;
    logic [1:0]  stateDbg2;

    int nChecks = 0;
    int nPass   = 0;

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .flag_n(flagN), .flag_z(flagZ), .flag_c(flagC), .flag_v(flagV),
        .stateDbg(stateDbg)
    );

    digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op), .a(a), .b(b),
        .busy(busy2), .done(done2), .result(result2),
        .flag_n(flagN2), .flag_z(flagZ2), .flag_c(flagC2), .flag_v(flagV2),
        .stateDbg(stateDbg2)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present a request, hold start across one rising edge, then drop it.
    task automatic launch(input logic o, input logic [15:0] x, input logic [15:0] y, input bit useDut2);
        @(negedge clk);
        op = o; a = x; b = y;
        if (useDut2) start2 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; start2 = 1'b0;
    endtask

    // Counts falling edges until done; lat stays 0 if the budget runs out.
    task automatic waitDone(input bit useDut2, output int lat, output int busyCnt);
        lat = 0; busyCnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (useDut2 ? busy2 : busy) busyCnt++;
            if (useDut2 ? done2 : done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; start2 = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h4321;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if ({busy, done, result, flagN, flagZ, flagC, flagV} !== 22'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h nzcv=%b%b%b%b, want all 0",
                     busy, done, result, flagN, flagZ, flagC, flagV);
        else nPass++;
        nChecks++;
        if ({busy2, done2, result2} !== 18'd0)
            $display("FAIL reset_outputs_dut2: got busy=%b done=%b result=%h, want all 0", busy2, done2, result2);
        else nPass++;
        start = 1'b0; start2 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_overflow;
        int lat, busyCnt;
        launch(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        waitDone(1'b0, lat, busyCnt);
        nChecks++;
        if (lat !== 5) $display("FAIL add_ovf_latency: got %0d, want 5", lat); else nPass++;
        nChecks++;
        if (busyCnt !== 4) $display("FAIL add_ovf_busy_cycles: got %0d, want 4", busyCnt); else nPass++;
        nChecks++;
        if (result !== 16'h8000) $display("FAIL add_ovf_result: got %h, want 8000", result); else nPass++;
        nChecks++;
        if ({flagN, flagZ, flagC, flagV} !== 4'b1001)
            $display("FAIL add_ovf_flags: got nzcv=%b%b%b%b, want 1001", flagN, flagZ, flagC, flagV);
        else nPass++;
        @(negedge clk);
        nChecks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL add_ovf_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
        else nPass++;
    endtask

    task automatic test_add_wrap;
        int lat, busyCnt;
        launch(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        waitDone(1'b0, lat, busyCnt);
        nChecks++;
        if (result !== 16'h0000 || {flagN, flagZ, flagC, flagV} !== 4'b0110)
            $display("FAIL add_wrap: got result=%h nzcv=%b%b%b%b, want 0000 0110", result, flagN, flagZ, flagC, flagV);
        else nPass++;
    endtask

    task automatic test_sub;
        int lat, busyCnt;
        launch(1'b1, 16'h0005, 16'h0005, 1'b0);
        waitDone(1'b0, lat, busyCnt);
        nChecks++;
        if (result !== 16'h0000 || {flagN, flagZ, flagC, flagV} !== 4'b0110)
            $display("FAIL sub_equal: got result=%h nzcv=%b%b%b%b, want 0000 0110", result, flagN, flagZ, flagC, flagV);
        else nPass++;
        launch(1'b1, 16'h0003, 16'h0005, 1'b0);
        waitDone(1'b0, lat, busyCnt);
        nChecks++;
        if (result !== 16'hFFFE || {flagN, flagZ, flagC, flagV} !== 4'b1000)
            $display("FAIL sub_borrow: got result=%h nzcv=%b%b%b%b, want fffe 1000", result, flagN, flagZ, flagC, flagV);
        else nPass++;
    endtask

    task automatic test_sub_overflow;
        int lat, busyCnt;
        launch(1'b1, 16'h8000, 16'h0001, 1'b0);
        waitDone(1'b0, lat, busyCnt);
        nChecks++;
        if (result !== 16'h7FFF || {flagN, flagZ, flagC, flagV} !== 4'b0011)
            $display("FAIL sub_ovf: got result=%h nzcv=%b%b%b%b, want 7fff 0011", result, flagN, flagZ, flagC, flagV);
        else nPass++;
    endtask

    task automatic test_start_ignored;
        int lat, busyCnt;
        launch(1'b0, 16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 16'hFFFF; b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        waitDone(1'b0, lat, busyCnt);
        nChecks++;
        if (lat !== 2) $display("FAIL ignored_start_latency: got %0d, want 2", lat); else nPass++;
        nChecks++;
        if (result !== 16'h2345 || {flagN, flagZ, flagC, flagV} !== 4'b0000)
            $display("FAIL ignored_start_result: got result=%h nzcv=%b%b%b%b, want 2345 0000", result, flagN, flagZ, flagC, flagV);
        else nPass++;
        @(negedge clk);
        nChecks++;
        if (busy !== 1'b0) $display("FAIL ignored_start_queued: got busy=%b, want 0", busy); else nPass++;
    endtask

    task automatic test_reset_abort;
        int doneSeen;
        launch(1'b0, 16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({busy, done, result, flagN, flagZ, flagC, flagV} !== 22'd0)
            $display("FAIL abort_outputs: got busy=%b done=%b result=%h nzcv=%b%b%b%b, want all 0",
                     busy, done, result, flagN, flagZ, flagC, flagV);
        else nPass++;
        doneSeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        nChecks++;
        if (doneSeen !== 0) $display("FAIL abort_no_done: got %0d active cycles, want 0", doneSeen); else nPass++;
    endtask

    task automatic test_back_to_back;
        int lat, busyCnt, gap;
        @(negedge clk);
        op = 1'b0; a = 16'h0001; b = 16'h0002; start = 1'b1;
        @(posedge clk);
        #1 a = 16'h00F0; b = 16'h000F;
        waitDone(1'b0, lat, busyCnt);
        nChecks++;
        if (lat !== 5 || result !== 16'h0003)
            $display("FAIL b2b_first: got lat=%0d result=%h, want 5 0003", lat, result);
        else nPass++;
        gap = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) begin
                gap = i;
                break;
            end
        end
        nChecks++;
        if (gap !== 5) $display("FAIL b2b_gap: got %0d, want 5", gap); else nPass++;
        nChecks++;
        if (result !== 16'h00FF || {flagN, flagZ, flagC, flagV} !== 4'b0000)
            $display("FAIL b2b_second: got result=%h nzcv=%b%b%b%b, want 00ff 0000", result, flagN, flagZ, flagC, flagV);
        else nPass++;
    endtask

    task automatic test_single_digit;
        int lat, busyCnt;
        launch(1'b0, 16'h7FFF, 16'h0001, 1'b1);
        waitDone(1'b1, lat, busyCnt);
        nChecks++;
        if (lat !== 2 || busyCnt !== 1)
            $display("FAIL single_digit_timing: got lat=%0d busy=%0d, want 2 1", lat, busyCnt);
        else nPass++;
        nChecks++;
        if (result2 !== 16'h8000 || {flagN2, flagZ2, flagC2, flagV2} !== 4'b1001)
            $display("FAIL single_digit_result: got result=%h nzcv=%b%b%b%b, want 8000 1001", result2, flagN2, flagZ2, flagC2, flagV2);
        else nPass++;
    endtask

    initial begin
        start = 1'b0; start2 = 1'b0; op = 1'b0; a = '0; b = '0; rst_n = 1'b0;
        test_reset();
        test_add_overflow();
        test_add_wrap();
        test_sub();
        test_sub_overflow();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_single_digit();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
